// File: rtl/api_channel_mux_if.sv
// Bundled API-port and per-channel handshake signals for api_channel_mux.
// The slave modport is the mux itself; master is the surrounding system side.
interface api_channel_mux_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 64,
  parameter int REG_W  = 8,
  parameter int CMD_W  = 8,
  parameter int SLOT_W = 5,
  parameter int FPGA_W = 4
) ();
  localparam int MSG_W = SLOT_W + FPGA_W + REG_W + CMD_W + DATA_W;

  logic                    api_i_empty_in;
  logic                    api_i_rd_en_out;
  logic [SLOT_W-1:0]       api_i_src_slot_in;
  logic [FPGA_W-1:0]       api_i_src_fpga_in;
  logic [REG_W-1:0]        api_i_src_reg_in;
  logic [REG_W-1:0]        api_i_tgt_reg_in;
  logic [CMD_W-1:0]        api_i_tgt_cmd_in;
  logic [DATA_W-1:0]       api_i_data_in;

  logic [NUM_CH-1:0]       ch_i_valid_out;
  logic [NUM_CH-1:0]       ch_i_ready_in;
  logic [NUM_CH*MSG_W-1:0] ch_i_msg_out;

  logic [NUM_CH-1:0]       ch_o_valid_in;
  logic [NUM_CH-1:0]       ch_o_ready_out;
  logic [NUM_CH*MSG_W-1:0] ch_o_msg_in;

  logic                    api_o_rfd_in;
  logic                    api_o_wr_en_out;
  logic [SLOT_W-1:0]       api_o_tgt_slot_out;
  logic [FPGA_W-1:0]       api_o_tgt_fpga_out;
  logic [REG_W-1:0]        api_o_tgt_reg_out;
  logic [CMD_W-1:0]        api_o_tgt_cmd_out;
  logic [REG_W-1:0]        api_o_src_reg_out;
  logic [CMD_W-1:0]        api_o_src_cmd_out;
  logic [DATA_W-1:0]       api_o_data_out;

  logic [NUM_CH-1:0]       ovf_flag_out;

  modport slave (
    input  api_i_empty_in, api_i_src_slot_in, api_i_src_fpga_in, api_i_src_reg_in,
           api_i_tgt_reg_in, api_i_tgt_cmd_in, api_i_data_in,
           ch_i_ready_in, ch_o_valid_in, ch_o_msg_in, api_o_rfd_in,
    output api_i_rd_en_out, ch_i_valid_out, ch_i_msg_out, ch_o_ready_out,
           api_o_wr_en_out, api_o_tgt_slot_out, api_o_tgt_fpga_out, api_o_tgt_reg_out,
           api_o_tgt_cmd_out, api_o_src_reg_out, api_o_src_cmd_out, api_o_data_out,
           ovf_flag_out
  );

  modport master (
    output api_i_empty_in, api_i_src_slot_in, api_i_src_fpga_in, api_i_src_reg_in,
           api_i_tgt_reg_in, api_i_tgt_cmd_in, api_i_data_in,
           ch_i_ready_in, ch_o_valid_in, ch_o_msg_in, api_o_rfd_in,
    input  api_i_rd_en_out, ch_i_valid_out, ch_i_msg_out, ch_o_ready_out,
           api_o_wr_en_out, api_o_tgt_slot_out, api_o_tgt_fpga_out, api_o_tgt_reg_out,
           api_o_tgt_cmd_out, api_o_src_reg_out, api_o_src_cmd_out, api_o_data_out,
           ovf_flag_out
  );
endinterface

// File: rtl/api_channel_mux.sv
// N-channel router: API inbound words demuxed into per-channel FWFT FIFOs,
// outbound channel requests round-robin arbitrated onto the single API output.
module api_channel_mux #(
  parameter int NUM_CH   = 4,
  parameter int CH_W     = 2,
  parameter int IN_DEPTH = 4,
  parameter int DATA_W   = 64,
  parameter int REG_W    = 8,
  parameter int CMD_W    = 8,
  parameter int SLOT_W   = 5,
  parameter int FPGA_W   = 4
) (
  input  logic               api_clk_in,
  input  logic               api_rst_in,
  api_channel_mux_if.slave   bus
);
  localparam int MSG_W = SLOT_W + FPGA_W + REG_W + CMD_W + DATA_W;
  localparam int PTR_W = $clog2(IN_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // ---------------- inbound demux ----------------
  logic [CH_W-1:0]   sel;
  logic [MSG_W-1:0]  in_msg;
  logic              pop_api;
  logic [NUM_CH-1:0] push, pop, valid, full;
  logic [CNT_W-1:0]  cnt [NUM_CH];
  logic [PTR_W-1:0]  wp  [NUM_CH];
  logic [PTR_W-1:0]  rp  [NUM_CH];
  logic [MSG_W-1:0]  mem [NUM_CH][IN_DEPTH];
  logic [NUM_CH-1:0] ovf;
  logic              unused_tgt_bits;

  assign sel             = bus.api_i_tgt_reg_in[CH_W-1:0];
  assign unused_tgt_bits = ^bus.api_i_tgt_reg_in[REG_W-1:CH_W];
  assign in_msg = {bus.api_i_src_slot_in, bus.api_i_src_fpga_in, bus.api_i_src_reg_in,
                   bus.api_i_tgt_cmd_in, bus.api_i_data_in};

  // Full is registered occupancy, so a word aimed at a full channel stalls
  // the whole API input even if that channel drains in the same cycle.
  always_comb begin
    full  = '0;
    valid = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      full[k]  = (cnt[k] == CNT_W'(IN_DEPTH));
      valid[k] = (cnt[k] != '0);
    end
  end

  assign pop_api = !api_rst_in && !bus.api_i_empty_in && !full[sel];

  always_comb begin
    push = '0;
    pop  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      push[k] = pop_api && (sel == CH_W'(k));
      pop[k]  = valid[k] && bus.ch_i_ready_in[k];
    end
  end

  always_ff @(posedge api_clk_in or posedge api_rst_in) begin
    if (api_rst_in) begin
      for (int k = 0; k < NUM_CH; k++) begin
        cnt[k] <= '0;
        wp[k]  <= '0;
        rp[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (push[k]) wp[k] <= wp[k] + 1'b1;
        if (pop[k])  rp[k] <= rp[k] + 1'b1;
        cnt[k] <= cnt[k] + CNT_W'(push[k]) - CNT_W'(pop[k]);
      end
    end
  end

  // Storage needs no reset; empty entries are masked at the output.
  always_ff @(posedge api_clk_in) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (push[k]) mem[k][wp[k]] <= in_msg;
    end
  end

  always_ff @(posedge api_clk_in or posedge api_rst_in) begin
    if (api_rst_in) begin
      ovf <= '0;
    end else if (!bus.api_i_empty_in && full[sel]) begin
      ovf[sel] <= 1'b1;
    end
  end

  always_comb begin
    bus.ch_i_msg_out = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      bus.ch_i_msg_out[k*MSG_W +: MSG_W] = valid[k] ? mem[k][rp[k]] : '0;
    end
  end

  assign bus.api_i_rd_en_out = pop_api;
  assign bus.ch_i_valid_out  = valid;
  assign bus.ovf_flag_out    = ovf;

  // ---------------- outbound arbiter ----------------
  logic [CH_W-1:0]   rr, gnt;
  logic              gnt_vld;
  logic [MSG_W-1:0]  o_msg [NUM_CH];
  logic [MSG_W-1:0]  o_sel;
  logic [SLOT_W-1:0] o_slot;
  logic [FPGA_W-1:0] o_fpga;
  logic [REG_W-1:0]  o_reg;
  logic [CMD_W-1:0]  o_cmd;
  logic [DATA_W-1:0] o_data;

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      o_msg[k] = bus.ch_o_msg_in[k*MSG_W +: MSG_W];
    end
  end

  // Scan downward so the channel closest after rr is the last (winning) write.
  always_comb begin
    logic [CH_W-1:0] idx;
    logic            any;
    gnt = '0;
    any = 1'b0;
    idx = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      idx = rr + CH_W'(i);
      if (bus.ch_o_valid_in[idx]) begin
        gnt = idx;
        any = 1'b1;
      end
    end
    gnt_vld = any && bus.api_o_rfd_in && !api_rst_in;
  end

  always_comb begin
    bus.ch_o_ready_out = '0;
    if (gnt_vld) bus.ch_o_ready_out[gnt] = 1'b1;
  end

  assign o_sel = o_msg[gnt];
  assign {o_slot, o_fpga, o_reg, o_cmd, o_data} = o_sel;

  always_ff @(posedge api_clk_in or posedge api_rst_in) begin
    if (api_rst_in) begin
      rr                     <= CH_W'(NUM_CH - 1);
      bus.api_o_wr_en_out    <= 1'b0;
      bus.api_o_tgt_slot_out <= '0;
      bus.api_o_tgt_fpga_out <= '0;
      bus.api_o_tgt_reg_out  <= '0;
      bus.api_o_tgt_cmd_out  <= '0;
      bus.api_o_src_reg_out  <= '0;
      bus.api_o_src_cmd_out  <= '0;
      bus.api_o_data_out     <= '0;
    end else begin
      bus.api_o_wr_en_out <= gnt_vld;
      if (gnt_vld) begin
        rr                     <= gnt;
        bus.api_o_tgt_slot_out <= o_slot;
        bus.api_o_tgt_fpga_out <= o_fpga;
        bus.api_o_tgt_reg_out  <= o_reg;
        bus.api_o_tgt_cmd_out  <= o_cmd;
        bus.api_o_src_reg_out  <= REG_W'(gnt);
        bus.api_o_src_cmd_out  <= o_cmd;
        bus.api_o_data_out     <= o_data;
      end
    end
  end
endmodule

// File: doc/api_channel_mux.md
Name: api_channel_mux

Overview:
- Parametrised N-channel message router between the SciEngines_API port and NUM_CH user cores.
- Successor to the single-core main-module hookup.
- Inbound words from the API input FIFO are demultiplexed to per-channel buffers using the low bits of the target register.
- Outbound channel requests are round-robin arbitrated onto the single API output port. The source register is stamped with the channel index so that replies route back.

Parameters:
NUM_CH, 4, number of user channels (power of two, 2..16)
CH_W, 2, log2(NUM_CH)
IN_DEPTH, 4, per-channel inbound FIFO depth (power of two, ≥2)
DATA_W, 64, message data width
REG_W, 8, register address width
CMD_W, 8, command width
SLOT_W, 5, slot address width
FPGA_W, 4, FPGA address width

Ports:
api_clk_in  in  1  single clock for the whole block
api_rst_in  in  1  asynchronous active-high reset
api_i_empty_in  in  1  API input FIFO empty
api_i_rd_en_out  out  1  pop API input FIFO (first-word-fall-through)
api_i_src_slot_in  in  SLOT_W  sender slot
api_i_src_fpga_in  in  FPGA_W  sender FPGA
api_i_src_reg_in  in  REG_W  sender register
api_i_tgt_reg_in  in  REG_W  target register; [CH_W-1:0] selects the channel
api_i_tgt_cmd_in  in  CMD_W  target command
api_i_data_in  in  DATA_W  payload
ch_i_valid_out  out  NUM_CH  per-channel inbound word valid
ch_i_ready_in  in  NUM_CH  per-channel inbound accept
ch_i_msg_out  out  NUM_CH*(SLOT_W+FPGA_W+REG_W+CMD_W+DATA_W)  packed {slot,fpga,src_reg,cmd,data}; channel k at slice k
ch_o_valid_in  in  NUM_CH  per-channel outbound request
ch_o_ready_out  out  NUM_CH  per-channel outbound grant/accept
ch_o_msg_in  in  NUM_CH*(SLOT_W+FPGA_W+REG_W+CMD_W+DATA_W)  packed {tgt_slot,tgt_fpga,tgt_reg,cmd,data}
api_o_rfd_in  in  1  API output ready-for-data
api_o_wr_en_out  out  1  API output write strobe
api_o_tgt_slot_out  out  SLOT_W  target slot
api_o_tgt_fpga_out  out  FPGA_W  target FPGA
api_o_tgt_reg_out  out  REG_W  target register
api_o_tgt_cmd_out  out  CMD_W  target command
api_o_src_reg_out  out  REG_W  zero-extended granted channel index
api_o_src_cmd_out  out  CMD_W  copy of the outbound cmd
api_o_data_out  out  DATA_W  payload
ovf_flag_out  out  NUM_CH  sticky: channel FIFO was full while head-of-line blocked

Behaviour:
- Reset (async assert, sync release): all FIFOs empty, all outputs 0, ovf_flag_out=0, RR pointer=NUM_CH-1 (channel 0 highest priority first).
- Inbound:
  - sel = api_i_tgt_reg_in[CH_W-1:0].
  - api_i_rd_en_out = !api_i_empty_in && !full[sel] (combinational). Full is registered state.
  - On a pop, the word is written into FIFO[sel] at the same edge. ch_i_valid_out[sel] rises the next cycle (1-cycle latency).
  - Channel FIFO: valid/ready, FWFT. An entry pops on the edge where valid&&ready.
  - Simultaneous push and pop on the same channel is legal; occupancy is unchanged.
  - Full FIFO: no push. A push is still allowed when full and a pop occur in the same cycle? No: push is gated on registered full only. The head word blocks all channels (in-order delivery).
  - ovf_flag_out[sel] is set when !api_i_empty_in && full[sel]; cleared only by reset.
- Outbound:
  - Eligible when api_o_rfd_in=1. Grant = first k with ch_o_valid_in[k], scanning from RR+1 modulo NUM_CH.
  - ch_o_ready_out[grant]=1 combinationally; all others 0. No grant when rfd=0 or no valid request.
  - On a grant edge: api_o_wr_en_out<=1, fields registered from ch_o_msg_in[grant], src_reg<=grant, RR<=grant.
  - On a non-grant edge: api_o_wr_en_out<=0; the data fields hold their last value.
  - Throughput is one word per cycle while rfd stays high.
  - The API guarantees ≥2 free entries when rfd falls, so the single in-flight registered write is lossless.
  - A channel holding valid high receives a grant within NUM_CH cycles of continuous rfd (no starvation).
- Reset mid-operation: buffered inbound words are discarded and a pending write is cancelled (wr_en forced 0 immediately).

Test Plan:
- Reset, then push one API word with tgt_reg=0x02, data=0xDEAD_BEEF_0000_0001. Expect rd_en for exactly 1 cycle. ch_i_valid_out=4'b0100 one cycle later, with matching msg.
- Push 5 words to channel 1 with ch_i_ready_in[1]=0, IN_DEPTH=4. Expect 4 pops, then rd_en=0 with api_i_empty_in=0, and ovf_flag_out[1]=1. Raise ready: the 5th word is delivered after the first 4, in order.
- All 4 channels hold valid, rfd=1 continuously. Expect grant order 0,1,2,3,0,… with wr_en=1 every cycle and src_reg_out matching the channel index.
- Channels 1 and 3 valid; drop rfd for 3 cycles after the first write. Expect wr_en=0 during the gap, no ready pulses, and resumption at channel 3.
- Simultaneous push and pop on a channel holding 2 entries for 10 cycles. Occupancy stays 2, data order is preserved, and ovf_flag_out stays 0.
- Assert api_rst_in asynchronously mid-transfer with a FIFO occupancy of 3. Outputs go to 0 immediately; after release ch_i_valid_out=0 and the first grant goes to channel 0.
